// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
// Two-stage pipelined bitwise logic unit with an internal accumulator and a
// valid/ready stream interface on both sides.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid / in_ready operand beat handshake (in_ready depends on out_ready)
//   a, b                WIDTH-bit operands (a replaced by acc when acc_en=1)
//   op                  0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A
//   acc_en              use acc as operand A, write result back on accept
//   acc_clr             clear acc at the next edge, checked every cycle
//   out_valid/out_ready result beat handshake
//   y, zero, ones, parity  result and its reduction flags (valid with out_valid)
module logic_unit_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             ones,
  output logic             parity
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] opnd_a;
  logic [WIDTH-1:0] result;
  logic             s1_valid;
  logic [WIDTH-1:0] s1_res;
  logic             s2_valid;
  logic             s2_adv;
  logic             accept;

  assign s2_adv   = !s2_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign accept   = in_valid && in_ready;
  assign opnd_a   = acc_en ? acc : a;
  assign out_valid = s2_valid;

  always_comb begin
    result = '0;
    unique case (op)
      3'd0: result = opnd_a & b;
      3'd1: result = opnd_a | b;
      3'd2: result = ~(opnd_a & b);
      3'd3: result = ~(opnd_a | b);
      3'd4: result = opnd_a ^ b;
      3'd5: result = ~(opnd_a ^ b);
      3'd6: result = ~opnd_a;
      3'd7: result = opnd_a;
      default: result = '0;
    endcase
  end

  // Stage 1: operation result. Only refills when S1 is empty or draining,
  // which is exactly when in_ready is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_res   <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_res   <= result;
    end else if (s1_valid && s2_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: output register plus flags. Held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      y        <= '0;
      zero     <= 1'b0;
      ones     <= 1'b0;
      parity   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        y      <= s1_res;
        zero   <= ~|s1_res;
        ones   <= &s1_res;
        parity <= ^s1_res;
      end
    end
  end

  // Accumulator is written at the accept edge, so a back-to-back acc_en beat
  // sees the updated value. Clear wins over the write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (acc_clr) begin
      acc <= '0;
    end else if (accept && acc_en) begin
      acc <= result;
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       acc_en;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       zero;
  logic       ones;
  logic       parity;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
    int         exp_cyc;
    bit         strict;
  } exp_t;

  exp_t q[$];

  logic       held_v = 1'b0;
  logic [10:0] held;

  logic_unit_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .zero(zero), .ones(ones), .parity(parity)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Offer one beat; push the expected response on the edge it is accepted.
  task automatic send(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] vop,
                      input logic ven, input logic vclr, input logic [7:0] ey, input bit strict);
    exp_t e;
    bit done = 0;
    in_valid = 1'b1; a = va; b = vb; op = vop; acc_en = ven; acc_clr = vclr;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.y = ey; e.z = (ey == 8'h00); e.o = (ey == 8'hFF); e.p = ^ey;
        e.exp_cyc = cyc + 2; e.strict = strict;
        q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
    end
    acc_clr = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0; acc_en = 1'b0; acc_clr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Monitor: compares every transferred result against the scoreboard and
  // checks that stalled outputs are held.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      held_v = 1'b0;
    end else if (out_valid) begin
      if (held_v) begin
        checks++;
        if ({y, zero, ones, parity} !== held) begin
          errors++;
          $display("FAIL hold_stable: got %0h expected %0h", {y, zero, ones, parity}, held);
        end
      end
      if (out_ready) begin
        held_v = 1'b0;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got y=%0h expected no output", y);
        end else begin
          e = q.pop_front();
          if ({y, zero, ones, parity} !== {e.y, e.z, e.o, e.p}) begin
            errors++;
            $display("FAIL result: got y=%0h z=%0b o=%0b p=%0b expected y=%0h z=%0b o=%0b p=%0b",
                     y, zero, ones, parity, e.y, e.z, e.o, e.p);
          end
          if (e.strict) begin
            checks++;
            if (cyc != e.exp_cyc) begin
              errors++;
              $display("FAIL latency: got cycle %0d expected %0d", cyc, e.exp_cyc);
            end
          end
        end
      end else begin
        held_v = 1'b1;
        held   = {y, zero, ones, parity};
      end
    end
  end

  logic [7:0] sweep_y [8];
  logic [7:0] bp_a [5];
  logic [7:0] bp_y [5];

  initial begin
    sweep_y = '{8'h48, 8'hDE, 8'hB7, 8'h21, 8'h96, 8'h69, 8'h35, 8'hCA};
    bp_a    = '{8'h11, 8'h22, 8'h0F, 8'h44, 8'h55};
    bp_y    = '{8'h11, 8'h22, 8'hF0, 8'h44, 8'h55};

    rst = 1'b1; in_valid = 1'b1; a = 8'hCA; b = 8'h5C; op = 3'd0;
    acc_en = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_y", y, 0);
    chk("reset_flags", {zero, ones, parity}, 0);
    rst = 1'b0;
    idle();
    #1;
    chk("post_reset_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Gate sweep, one beat per cycle
    for (int i = 0; i < 8; i++) send(8'hCA, 8'h5C, 3'(i), 1'b0, 1'b0, sweep_y[i], 1'b1);
    idle();
    wait_drain();

    // Flags
    send(8'h3C, 8'h3C, 3'd5, 1'b0, 1'b0, 8'hFF, 1'b1);
    send(8'h3C, 8'h3C, 3'd4, 1'b0, 1'b0, 8'h00, 1'b1);
    idle();
    wait_drain();

    // Accumulator chain
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    send(8'hEE, 8'h01, 3'd1, 1'b1, 1'b0, 8'h01, 1'b1);
    send(8'hEE, 8'h80, 3'd1, 1'b1, 1'b0, 8'h81, 1'b1);
    send(8'hEE, 8'hFF, 3'd4, 1'b1, 1'b0, 8'h7E, 1'b1);
    send(8'hEE, 8'h00, 3'd1, 1'b1, 1'b1, 8'h7E, 1'b1);
    send(8'hEE, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00, 1'b1);
    idle();
    wait_drain();

    // Backpressure
    fork
      begin
        for (int i = 0; i < 5; i++)
          send(bp_a[i], 8'h00, (bp_a[i] == 8'h0F) ? 3'd6 : 3'd7, 1'b0, 1'b0, bp_y[i], 1'b0);
        idle();
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
          @(posedge clk); #1;
          if (out_valid) seen = 1;
        end
        chk("bp_first_result_seen", seen, 1);
        out_ready = 1'b0;
        #1;
        chk("bp_full_stall_in_ready", in_ready, 0);
        repeat (4) @(posedge clk);
        #1;
        chk("bp_stall_still_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1);
      end
    join
    wait_drain();

    // Reset mid-stream with two beats in flight
    send(8'h00, 8'h55, 3'd1, 1'b1, 1'b0, 8'h55, 1'b1);
    send(8'h11, 8'h00, 3'd7, 1'b0, 1'b0, 8'h11, 1'b1);
    idle();
    rst = 1'b1;
    @(posedge clk); #1;
    q.delete();
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;
    send(8'hEE, 8'h00, 3'd1, 1'b1, 1'b0, 8'h00, 1'b1);
    idle();
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, pipelined bitwise logic unit: the multi-bit, registered successor of the two-input gate block. It applies one of eight bitwise operations to WIDTH-bit operands, optionally chains results through an internal accumulator, and returns the result with reduction flags over a valid/ready stream interface. It sits between an operand source and any downstream consumer that may apply backpressure.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand beat offered
- in_ready  out  1  unit can accept a beat this cycle
- a  in  WIDTH  operand A (ignored when acc_en=1)
- b  in  WIDTH  operand B
- op  in  3  operation select, sampled with the beat
- acc_en  in  1  use accumulator as operand A and write result back to it
- acc_clr  in  1  clear accumulator (sampled every cycle, independent of handshake)
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result this cycle
- y  out  WIDTH  result
- zero  out  1  y == 0
- ones  out  1  y == all ones
- parity  out  1  XOR-reduction of y

## Operation
- op encoding: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 BUF A (B ignored for 6/7).
- Operand A = acc when acc_en=1, else a.
- Beat accepted when in_valid && in_ready.
- Stage 1 (S1): on accept, result = f(op, A, b) registered with s1_valid.
- Stage 2 (S2): S1 result moves to y; zero/ones/parity computed from it and registered alongside; out_valid = s2_valid.
- Flow: s2_adv = !s2_valid || out_ready; s1 moves into S2 when s1_valid && s2_adv; in_ready = !rst && (!s1_valid || s2_adv). in_ready is combinational from out_ready.
- S2 cleared (out_valid→0) when out_ready && !s1_valid at the edge; S1 cleared when it moves and no new beat is accepted.
- Accumulator acc (WIDTH bits): on an accepted beat with acc_en=1, acc ← result at that edge. Beats with acc_en=0 leave acc unchanged.
- acc_clr=1: acc ← 0 at next edge; wins over a simultaneous acc_en write. A beat accepted in the same cycle still uses the pre-clear acc as operand.
- Back-to-back acc_en beats are hazard-free: acc is updated at the accept edge, so the next beat sees it.
- While out_valid && !out_ready, y and flags are held stable; no beat is dropped or duplicated.

## Timing
- Reset (rst high at edge): out_valid=0, y=0, zero=0, ones=0, parity=0, acc=0, S1 empty; in_ready=0 while rst high, 1 in the first cycle after.
- Reset mid-operation discards all in-flight beats; no partial output.
- Latency: beat accepted at edge k → out_valid=1 with its y after edge k+1 (visible in the cycle following k+1, i.e. two register stages).
- Throughput: one beat per cycle with out_ready held high.
- Full stall: with S1 and S2 occupied and out_ready=0, in_ready=0; on out_ready=1 both stages advance and in_ready=1 the same cycle.
- Flags are valid only when out_valid=1.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 → out_valid=0, y=0, flags 0, in_ready=0; after release, in_ready=1.
- Gate sweep (WIDTH=8, a=0xCA, b=0x5C, op 0..7, out_ready=1) → y = 0x48, 0xDE, 0xB7, 0x21, 0x96, 0x69, 0x35, 0xCA, each two stages after its accept, one per cycle; parity for 0x48 = 0, zero=0, ones=0.
- Flags: op=5, a=b=0x3C → y=0xFF, ones=1, parity=0; op=4, a=b=0x3C → y=0x00, zero=1.
- Accumulator chain: acc_clr pulse, then acc_en beats op=1 b=0x01, op=1 b=0x80, op=4 b=0xFF back-to-back → y = 0x01, 0x81, 0x7E; same-cycle acc_clr with a fourth beat op=1 b=0x00 → y=0x7E, following acc_en beat op=1 b=0x00 → y=0x00.
- Backpressure: stream 5 beats, out_ready=0 for 4 cycles after first result → y held stable, in_ready=0 once both stages full, all 5 results delivered in order with no loss/duplication.
- Reset mid-stream with 2 beats in flight → out_valid=0 next cycle, acc=0, no stale result emerges afterwards.
